// File: rtl/mul_arbiter_pkg.sv
// Shared vALU definitions for the multiplier arbiter: FSM encoding, default
// multiplier latency and the in-flight result tag layout.
package mul_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_e;

    localparam int unsigned MUL_PIPE_LAT = 4;

    // valid must stay the MSB: mul_tag_pipe derives its occupancy from it.
    typedef struct packed {
        logic valid;
        logic owner;
        logic last;
    } mul_tag_t;

    localparam int unsigned MUL_TAG_WIDTH = $bits(mul_tag_t);

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mul_tag_pipe.sv
// Fixed-depth tag shift register tracking results inside the multiplier.
// The MSB of each entry is its valid bit; any_valid reports pipeline occupancy.
module mul_tag_pipe #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    output logic             any_valid
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_data = stage[DEPTH-1];

    always_comb begin
        any_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage[i][WIDTH-1];
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Two-requester burst arbiter in front of the vector multiplier: locks a grant
// per burst, round-robins on contention and tags results back to their owner.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned OPSEL_WIDTH = 2,
    parameter int unsigned SEW_WIDTH   = 2,
    parameter int unsigned PIPE_LAT    = MUL_PIPE_LAT
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req0_valid,
    input  logic                   req0_last,
    input  logic [DATA_WIDTH-1:0]  req0_vec0,
    input  logic [DATA_WIDTH-1:0]  req0_vec1,
    input  logic [OPSEL_WIDTH-1:0] req0_opSel,
    input  logic [SEW_WIDTH-1:0]   req0_sew,
    output logic                   req0_ready,

    input  logic                   req1_valid,
    input  logic                   req1_last,
    input  logic [DATA_WIDTH-1:0]  req1_vec0,
    input  logic [DATA_WIDTH-1:0]  req1_vec1,
    input  logic [OPSEL_WIDTH-1:0] req1_opSel,
    input  logic [SEW_WIDTH-1:0]   req1_sew,
    output logic                   req1_ready,

    output logic [DATA_WIDTH-1:0]  mul_vec0,
    output logic [DATA_WIDTH-1:0]  mul_vec1,
    output logic [OPSEL_WIDTH-1:0] mul_opSel,
    output logic [SEW_WIDTH-1:0]   mul_sew,
    output logic                   mul_valid,

    output logic [1:0]             resp_valid,
    output logic                   resp_last,
    output logic                   busy
);

    arb_state_e             state, state_next;
    logic                   rr_ptr, rr_ptr_next;
    logic [OPSEL_WIDTH-1:0] opsel_q;
    logic [SEW_WIDTH-1:0]   sew_q;
    logic                   first_q;

    logic                   accept;
    logic                   accept_owner;
    logic                   accept_last;
    logic [OPSEL_WIDTH-1:0] beat_opsel;
    logic [SEW_WIDTH-1:0]   beat_sew;

    mul_tag_t               tag_in;
    mul_tag_t               tag_out;
    logic                   pipe_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            rr_ptr  <= 1'b0;
            opsel_q <= '0;
            sew_q   <= '0;
            first_q <= 1'b1;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
            if (accept && first_q) begin
                opsel_q <= beat_opsel;
                sew_q   <= beat_sew;
            end
            if (state == ARB_IDLE) begin
                first_q <= 1'b1;
            end else if (accept) begin
                first_q <= 1'b0;
            end
        end
    end

    // Grant is held for the whole burst; a stalled owner just issues nothing.
    always_comb begin
        state_next   = state;
        rr_ptr_next  = rr_ptr;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        accept       = 1'b0;
        accept_owner = 1'b0;
        accept_last  = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_next = rr_ptr ? ARB_GRANT1 : ARB_GRANT0;
                end else if (req0_valid) begin
                    state_next = ARB_GRANT0;
                end else if (req1_valid) begin
                    state_next = ARB_GRANT1;
                end
            end
            ARB_GRANT0: begin
                req0_ready = 1'b1;
                if (req0_valid) begin
                    accept      = 1'b1;
                    accept_last = req0_last;
                    if (req0_last) begin
                        state_next  = ARB_IDLE;
                        rr_ptr_next = 1'b1;
                    end
                end
            end
            ARB_GRANT1: begin
                req1_ready = 1'b1;
                if (req1_valid) begin
                    accept       = 1'b1;
                    accept_owner = 1'b1;
                    accept_last  = req1_last;
                    if (req1_last) begin
                        state_next  = ARB_IDLE;
                        rr_ptr_next = 1'b0;
                    end
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        beat_opsel = accept_owner ? req1_opSel : req0_opSel;
        beat_sew   = accept_owner ? req1_sew   : req0_sew;
        mul_valid  = accept;
        mul_vec0   = '0;
        mul_vec1   = '0;
        mul_opSel  = '0;
        mul_sew    = '0;
        // First beat forwards its own mode; the register only holds it from then on.
        if (accept) begin
            mul_vec0  = accept_owner ? req1_vec0 : req0_vec0;
            mul_vec1  = accept_owner ? req1_vec1 : req0_vec1;
            mul_opSel = first_q ? beat_opsel : opsel_q;
            mul_sew   = first_q ? beat_sew   : sew_q;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = accept;
        tag_in.owner = accept_owner;
        tag_in.last  = accept_last;
    end

    mul_tag_pipe #(
        .DEPTH (PIPE_LAT),
        .WIDTH (MUL_TAG_WIDTH)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_data   (tag_in),
        .out_data  (tag_out),
        .any_valid (pipe_busy)
    );

    always_comb begin
        resp_valid = tag_out.valid ? owner_onehot(tag_out.owner) : 2'b00;
        resp_last  = tag_out.valid & tag_out.last;
        busy       = (state != ARB_IDLE) | pipe_busy;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of each operand vector.
REQ-002 SHALL have parameter OPSEL_WIDTH, default 2, operand-signedness select width.
REQ-003 SHALL have parameter SEW_WIDTH, default 2, element-width code width.
REQ-004 SHALL have parameter PIPE_LAT, default 4, fixed cycles from mul_valid to multiplier result.
REQ-005 SHALL have port clk  in  1  clock; all logic on posedge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports reqN_valid / reqN_last  in  1 each (N=0,1)  beat offered / final beat of burst.
REQ-008 SHALL have ports reqN_vec0, reqN_vec1  in  DATA_WIDTH each  operand vectors.
REQ-009 SHALL have ports reqN_opSel  in  OPSEL_WIDTH and reqN_sew  in  SEW_WIDTH  burst mode.
REQ-010 SHALL have port reqN_ready  out  1  beat accepted when valid&ready.
REQ-011 SHALL have ports mul_vec0, mul_vec1 (DATA_WIDTH), mul_opSel, mul_sew, mul_valid  out  issue to operand selector.
REQ-012 SHALL have port resp_valid  out  2  one-hot owner of result leaving pipeline this cycle.
REQ-013 SHALL have ports resp_last  out  1 (final result of burst) and busy  out  1 (not idle or results in flight).

Function
REQ-014 SHALL implement FSM IDLE, GRANT0, GRANT1; reqN_ready=1 only in GRANTN.
REQ-015 IDLE: only one valid -> grant it next cycle; both -> grant rr_ptr; none -> stay IDLE.
REQ-016 GRANTN: on accepted beat with reqN_last=1, SHALL return to IDLE and set rr_ptr to the other requester.
REQ-017 Grant SHALL be locked for the burst; reqN_valid low mid-burst -> stay GRANTN, no beat issued, other requester ignored.
REQ-018 opSel/sew SHALL be latched from the first accepted beat of a burst and driven on mul_opSel/mul_sew for all beats; later beat values ignored.
REQ-019 mul_valid SHALL equal the accepted-beat strobe; mul_vec0/mul_vec1 combinationally mux the granted requester's vectors; both zero when mul_valid=0.
REQ-020 SHALL keep a PIPE_LAT-deep tag shift register {valid, owner, last}, loaded on each accepted beat, advancing every cycle.
REQ-021 resp_valid/resp_last SHALL be driven from the last tag stage, exactly PIPE_LAT cycles after the beat's mul_valid.
REQ-022 One bubble cycle (IDLE) SHALL occur between bursts; single-beat burst (last on first beat) SHALL be legal.
REQ-023 busy SHALL be 1 when state!=IDLE or any tag stage valid.

Reset
REQ-024 On rst: state IDLE, rr_ptr=0, latched opSel/sew=0, all tag stages cleared, next cycle all outputs 0.
REQ-025 rst mid-burst or with results in flight SHALL drop them; no resp_valid until new beats issued.

Structure
REQ-026 FSM state encoding and default PIPE_LAT SHALL live in the shared vALU package.
REQ-027 Tag shift register SHALL be a sub-module mul_tag_pipe (params DEPTH, WIDTH).

Verification
REQ-028 Req0 3-beat burst, sew=01, opSel=11 -> ready at cycle 1-3, mul_valid 3 cycles, resp_valid=01 at cycles 5-7, resp_last at 7.
REQ-029 Both valid in IDLE after reset -> GRANT0 first; after req0 last, req1 granted with one IDLE cycle gap; next contention -> req0.
REQ-030 Req1 drops valid for 2 cycles mid-burst while req0 valid -> GRANT1 held, mul_valid=0 those cycles, req0_ready stays 0.
REQ-031 Req0 changes sew 00->11 on beat 2 -> mul_sew stays 00 for whole burst.
REQ-032 rst asserted 2 cycles after a 4-beat burst starts -> next cycle state IDLE, busy=0, no resp_valid afterward.
REQ-033 Single-beat bursts alternating req0/req1 -> issue every 2nd cycle, resp owners alternate 01/10, each with resp_last=1.
